// File: rtl/riscv_exec_pipe.sv
// riscv_exec_pipe: RV32I execute unit with a RESULT_STAGES-deep result pipeline,
// valid/accept issue, writeback backpressure, flush, in-flight rd scoreboard and an
// optionally registered branch port (BRANCH_REG).
// Optional build macro RISCV_EXEC_PIPE_BYPASS_EN forwards in-flight results onto
// the source operands; without it operands are used exactly as supplied.
// One-hot opcode_instr_i bit numbering is given by the ENUM_INST_* localparams;
// any other bit (loads, stores, system ops) is executed as an unknown op.
module riscv_exec_pipe #(
    parameter int unsigned RESULT_STAGES = 1,
    parameter int unsigned BRANCH_REG    = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        opcode_valid_i,
    output logic        opcode_accept_o,
    input  logic [55:0] opcode_instr_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_ra_idx_i,
    input  logic [4:0]  opcode_rb_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic [31:0] reset_vector_i,
    input  logic        flush_i,
    input  logic        writeback_ready_i,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_idx_o,
    output logic [31:0] writeback_value_o,
    output logic        branch_request_o,
    output logic [31:0] branch_pc_o,
    output logic [31:0] busy_rd_mask_o
);
    localparam int unsigned ENUM_INST_ANDI = 0,  ENUM_INST_ADDI = 1,  ENUM_INST_SLTI = 2,
                            ENUM_INST_SLTIU = 3, ENUM_INST_ORI = 4,   ENUM_INST_XORI = 5,
                            ENUM_INST_SLLI = 6,  ENUM_INST_SRLI = 7,  ENUM_INST_SRAI = 8,
                            ENUM_INST_LUI = 9,   ENUM_INST_AUIPC = 10, ENUM_INST_ADD = 11,
                            ENUM_INST_SUB = 12,  ENUM_INST_SLT = 13,  ENUM_INST_SLTU = 14,
                            ENUM_INST_XOR = 15,  ENUM_INST_OR = 16,   ENUM_INST_AND = 17,
                            ENUM_INST_SLL = 18,  ENUM_INST_SRL = 19,  ENUM_INST_SRA = 20,
                            ENUM_INST_JAL = 21,  ENUM_INST_JALR = 22, ENUM_INST_BEQ = 23,
                            ENUM_INST_BNE = 24,  ENUM_INST_BLT = 25,  ENUM_INST_BGE = 26,
                            ENUM_INST_BLTU = 27, ENUM_INST_BGEU = 28;
    localparam int unsigned LAST = RESULT_STAGES - 1;

    logic                     boot_q;
    logic [RESULT_STAGES-1:0] stg_valid_q;
    logic [4:0]               stg_idx_q   [RESULT_STAGES];
    logic [31:0]              stg_value_q [RESULT_STAGES];
    logic [RESULT_STAGES-1:0] stg_adv;
    logic [31:0]              ra_val, rb_val, imm_i, imm_u, imm_b, imm_j;
    logic [4:0]               shamt_i, shamt_r, res_idx;
    logic [31:0]              res_value, br_target, branch_pc_c;
    logic                     res_wr, br_taken, branch_now_c;
    logic                     unused_ok;

    assign imm_i   = {{20{opcode_opcode_i[31]}}, opcode_opcode_i[31:20]};
    assign imm_u   = {opcode_opcode_i[31:12], 12'd0};
    assign imm_b   = {{19{opcode_opcode_i[31]}}, opcode_opcode_i[31], opcode_opcode_i[7],
                      opcode_opcode_i[30:25], opcode_opcode_i[11:8], 1'b0};
    assign imm_j   = {{11{opcode_opcode_i[31]}}, opcode_opcode_i[31], opcode_opcode_i[19:12],
                      opcode_opcode_i[20], opcode_opcode_i[30:21], 1'b0};
    assign shamt_i = opcode_opcode_i[24:20];
    assign shamt_r = rb_val[4:0];
    assign unused_ok = ^{opcode_opcode_i[6:0], opcode_instr_i[55:29],
                         opcode_ra_idx_i, opcode_rb_idx_i};

`ifdef RISCV_EXEC_PIPE_BYPASS_EN
    // Operand select: youngest valid stage with a matching non-zero rd wins
    always_comb begin
        ra_val = opcode_ra_operand_i;
        rb_val = opcode_rb_operand_i;
        for (int k = int'(RESULT_STAGES) - 1; k >= 0; k--) begin
            if (stg_valid_q[k] && opcode_ra_idx_i != 5'd0 && stg_idx_q[k] == opcode_ra_idx_i)
                ra_val = stg_value_q[k];
            if (stg_valid_q[k] && opcode_rb_idx_i != 5'd0 && stg_idx_q[k] == opcode_rb_idx_i)
                rb_val = stg_value_q[k];
        end
    end
`else
    assign ra_val = opcode_ra_operand_i;
    assign rb_val = opcode_rb_operand_i;
`endif

    // Stage 0: decode, ALU and branch resolution
    always_comb begin
        res_value = 32'd0;
        res_wr    = 1'b1;
        br_taken  = 1'b0;
        br_target = opcode_pc_i + imm_b;
        case (1'b1)
            opcode_instr_i[ENUM_INST_ANDI]:  res_value = ra_val & imm_i;
            opcode_instr_i[ENUM_INST_ADDI]:  res_value = ra_val + imm_i;
            opcode_instr_i[ENUM_INST_SLTI]:  res_value = {31'd0, $signed(ra_val) < $signed(imm_i)};
            opcode_instr_i[ENUM_INST_SLTIU]: res_value = {31'd0, ra_val < imm_i};
            opcode_instr_i[ENUM_INST_ORI]:   res_value = ra_val | imm_i;
            opcode_instr_i[ENUM_INST_XORI]:  res_value = ra_val ^ imm_i;
            opcode_instr_i[ENUM_INST_SLLI]:  res_value = ra_val << shamt_i;
            opcode_instr_i[ENUM_INST_SRLI]:  res_value = ra_val >> shamt_i;
            opcode_instr_i[ENUM_INST_SRAI]:  res_value = $unsigned($signed(ra_val) >>> shamt_i);
            opcode_instr_i[ENUM_INST_LUI]:   res_value = imm_u;
            opcode_instr_i[ENUM_INST_AUIPC]: res_value = opcode_pc_i + imm_u;
            opcode_instr_i[ENUM_INST_ADD]:   res_value = ra_val + rb_val;
            opcode_instr_i[ENUM_INST_SUB]:   res_value = ra_val - rb_val;
            opcode_instr_i[ENUM_INST_SLT]:   res_value = {31'd0, $signed(ra_val) < $signed(rb_val)};
            opcode_instr_i[ENUM_INST_SLTU]:  res_value = {31'd0, ra_val < rb_val};
            opcode_instr_i[ENUM_INST_XOR]:   res_value = ra_val ^ rb_val;
            opcode_instr_i[ENUM_INST_OR]:    res_value = ra_val | rb_val;
            opcode_instr_i[ENUM_INST_AND]:   res_value = ra_val & rb_val;
            opcode_instr_i[ENUM_INST_SLL]:   res_value = ra_val << shamt_r;
            opcode_instr_i[ENUM_INST_SRL]:   res_value = ra_val >> shamt_r;
            opcode_instr_i[ENUM_INST_SRA]:   res_value = $unsigned($signed(ra_val) >>> shamt_r);
            opcode_instr_i[ENUM_INST_JAL]: begin
                res_value = opcode_pc_i + 32'd4;
                br_taken  = 1'b1;
                br_target = opcode_pc_i + imm_j;
            end
            opcode_instr_i[ENUM_INST_JALR]: begin
                res_value = opcode_pc_i + 32'd4;
                br_taken  = 1'b1;
                br_target = (ra_val + imm_i) & ~32'd1;
            end
            opcode_instr_i[ENUM_INST_BEQ]:  begin res_wr = 1'b0; br_taken = ra_val == rb_val; end
            opcode_instr_i[ENUM_INST_BNE]:  begin res_wr = 1'b0; br_taken = ra_val != rb_val; end
            opcode_instr_i[ENUM_INST_BLT]:  begin res_wr = 1'b0; br_taken = $signed(ra_val) < $signed(rb_val); end
            opcode_instr_i[ENUM_INST_BGE]:  begin res_wr = 1'b0; br_taken = $signed(ra_val) >= $signed(rb_val); end
            opcode_instr_i[ENUM_INST_BLTU]: begin res_wr = 1'b0; br_taken = ra_val < rb_val; end
            opcode_instr_i[ENUM_INST_BGEU]: begin res_wr = 1'b0; br_taken = ra_val >= rb_val; end
            default: res_wr = 1'b0;
        endcase
        res_idx = (res_wr && opcode_rd_idx_i != 5'd0) ? opcode_rd_idx_i : 5'd0;
    end

    // Stage k moves unless it and every later stage are full while writeback stalls
    always_comb begin
        stg_adv = '0;
        for (int unsigned k = 0; k < RESULT_STAGES; k++) begin
            logic all_full;
            all_full = 1'b1;
            for (int unsigned j = k; j < RESULT_STAGES; j++)
                all_full = all_full & stg_valid_q[j];
            stg_adv[k] = ~all_full | writeback_ready_i;
        end
    end

    assign opcode_accept_o = opcode_valid_i & ~boot_q & ~flush_i & stg_adv[0];

    // Result pipeline and boot flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            boot_q      <= 1'b1;
            stg_valid_q <= '0;
            for (int unsigned k = 0; k < RESULT_STAGES; k++) begin
                stg_idx_q[k]   <= 5'd0;
                stg_value_q[k] <= 32'd0;
            end
        end else begin
            boot_q <= 1'b0;
            if (stg_adv[0]) begin
                stg_valid_q[0] <= opcode_accept_o;
                stg_idx_q[0]   <= res_idx;
                stg_value_q[0] <= res_value;
            end
            for (int unsigned k = 1; k < RESULT_STAGES; k++) begin
                if (stg_adv[k]) begin
                    stg_valid_q[k] <= stg_valid_q[k-1];
                    stg_idx_q[k]   <= stg_idx_q[k-1];
                    stg_value_q[k] <= stg_value_q[k-1];
                end
            end
            if (flush_i)
                stg_valid_q <= '0;
        end
    end

    // In-flight destination scoreboard
    always_comb begin
        busy_rd_mask_o = 32'd0;
        for (int unsigned k = 0; k < RESULT_STAGES; k++)
            if (stg_valid_q[k])
                busy_rd_mask_o[stg_idx_q[k]] = 1'b1;
        busy_rd_mask_o[0] = 1'b0;
    end

    assign writeback_valid_o = stg_valid_q[LAST];
    assign writeback_idx_o   = stg_idx_q[LAST];
    assign writeback_value_o = stg_value_q[LAST];

    assign branch_now_c = boot_q | (opcode_accept_o & br_taken);
    assign branch_pc_c  = boot_q ? reset_vector_i : br_target;

    generate
        if (BRANCH_REG != 0) begin : g_branch_reg
            logic        branch_req_q;
            logic [31:0] branch_pc_q;
            // Registered redirect, one cycle after resolution
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    branch_req_q <= 1'b0;
                    branch_pc_q  <= 32'd0;
                end else begin
                    branch_req_q <= branch_now_c;
                    branch_pc_q  <= branch_pc_c;
                end
            end
            assign branch_request_o = branch_req_q;
            assign branch_pc_o      = branch_pc_q;
        end else begin : g_branch_comb
            // Boot flag is already set while in reset; keep the redirect quiet until release
            assign branch_request_o = rst_ni & branch_now_c;
            assign branch_pc_o      = branch_pc_c;
        end
    endgenerate
endmodule
